// File: rtl/kernel3_gmem_c_m_axi_wthrottle_mo.sv
// Store-and-forward AXI write throttle: AW issues only once its whole burst is buffered
// (or via cut-through escape for oversize bursts), with a cap on outstanding B responses.
module kernel3_gmem_c_m_axi_wthrottle_mo #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 8,
  parameter int unsigned DATA_DEPTH      = 16,
  parameter int unsigned MAXREQS         = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clk_en,
  input  logic [ADDR_WIDTH-1:0]   in_TOP_AWADDR,
  input  logic [LEN_WIDTH-1:0]    in_TOP_AWLEN,
  input  logic                    in_TOP_AWVALID,
  output logic                    out_TOP_AWREADY,
  input  logic [DATA_WIDTH-1:0]   in_TOP_WDATA,
  input  logic [DATA_WIDTH/8-1:0] in_TOP_WSTRB,
  input  logic                    in_TOP_WLAST,
  input  logic                    in_TOP_WVALID,
  output logic                    out_TOP_WREADY,
  output logic [ADDR_WIDTH-1:0]   out_BUS_AWADDR,
  output logic [LEN_WIDTH-1:0]    out_BUS_AWLEN,
  output logic                    out_BUS_AWVALID,
  input  logic                    in_BUS_AWREADY,
  output logic [DATA_WIDTH-1:0]   out_BUS_WDATA,
  output logic [DATA_WIDTH/8-1:0] out_BUS_WSTRB,
  output logic                    out_BUS_WLAST,
  output logic                    out_BUS_WVALID,
  input  logic                    in_BUS_WREADY,
  input  logic                    in_BUS_BVALID,
  input  logic                    in_BUS_BREADY,
  output logic [7:0]              out_outstanding,
  output logic                    out_escape
);

  localparam int unsigned SW  = DATA_WIDTH / 8;
  localparam int unsigned RAW = $clog2(MAXREQS);
  localparam int unsigned RCW = RAW + 1;
  localparam int unsigned DAW = $clog2(DATA_DEPTH);
  localparam int unsigned CW  = DAW + 1;
  localparam int unsigned RW  = LEN_WIDTH + ADDR_WIDTH;
  localparam int unsigned DW  = 1 + SW + DATA_WIDTH;

  localparam logic [RCW-1:0] ReqFull  = RCW'(MAXREQS);
  localparam logic [CW-1:0]  DataFull = CW'(DATA_DEPTH);
  localparam logic [7:0]     MaxOut   = 8'(MAX_OUTSTANDING);

  logic [RW-1:0] req_mem [MAXREQS];
  logic [DW-1:0] data_mem [DATA_DEPTH];

  logic [RAW-1:0]        req_wr_q, req_wr_d, req_rd_q, req_rd_d;
  logic [RCW-1:0]        req_cnt_q, req_cnt_d;
  logic                  req_full_n_q, req_full_n_d;
  logic [DAW-1:0]        data_wr_q, data_wr_d, data_rd_q, data_rd_d;
  logic [CW-1:0]         data_cnt_q, data_cnt_d;
  logic                  data_full_n_q, data_full_n_d;
  logic [CW-1:0]         full_cnt_q, full_cnt_d;
  logic [CW-1:0]         owed_cnt_q, owed_cnt_d;
  logic [7:0]            outstanding_q, outstanding_d;
  logic                  escape_q, escape_d;
  logic                  awvalid_q, awvalid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [LEN_WIDTH-1:0]  awlen_q, awlen_d;

  logic          req_push, req_empty_n, data_push, data_pop, data_empty_n;
  logic          push_last, pop_last, b_hs, burst_ok, aw_load;
  logic [RW-1:0] req_head;
  logic [DW-1:0] data_head;

  assign req_empty_n  = (req_cnt_q != '0);
  assign data_empty_n = (data_cnt_q != '0);
  assign req_head     = req_mem[req_rd_q];
  assign data_head    = data_mem[data_rd_q];

  assign out_TOP_AWREADY = clk_en & req_full_n_q;
  assign out_TOP_WREADY  = clk_en & data_full_n_q;
  assign out_BUS_WVALID  = clk_en & data_empty_n & (owed_cnt_q != '0);

  assign req_push  = in_TOP_AWVALID & out_TOP_AWREADY;
  assign data_push = in_TOP_WVALID & out_TOP_WREADY;
  assign data_pop  = out_BUS_WVALID & in_BUS_WREADY;
  assign push_last = data_push & in_TOP_WLAST;
  assign pop_last  = data_pop & data_head[DW-1];
  assign b_hs      = clk_en & in_BUS_BVALID & in_BUS_BREADY;

  // Escape mode issues the oversize burst's AW once nothing earlier is still owed data.
  assign burst_ok = escape_q ? (owed_cnt_q == '0) : (full_cnt_q > owed_cnt_q);
  assign aw_load  = clk_en & req_empty_n & (outstanding_q < MaxOut) & burst_ok &
                    (~awvalid_q | in_BUS_AWREADY);

  assign out_BUS_AWADDR  = awaddr_q;
  assign out_BUS_AWLEN   = awlen_q;
  assign out_BUS_AWVALID = awvalid_q;
  assign out_BUS_WDATA   = data_empty_n ? data_head[DATA_WIDTH-1:0] : '0;
  assign out_BUS_WSTRB   = data_empty_n ? data_head[DATA_WIDTH +: SW] : '0;
  assign out_BUS_WLAST   = data_empty_n & data_head[DW-1];
  assign out_outstanding = outstanding_q;
  assign out_escape      = escape_q;

  always_ff @(posedge clk) begin
    if (req_push) req_mem[req_wr_q] <= {in_TOP_AWLEN, in_TOP_AWADDR};
    if (data_push) data_mem[data_wr_q] <= {in_TOP_WLAST, in_TOP_WSTRB, in_TOP_WDATA};
  end

  always_comb begin
    req_wr_d      = req_wr_q;
    req_rd_d      = req_rd_q;
    req_cnt_d     = req_cnt_q;
    data_wr_d     = data_wr_q;
    data_rd_d     = data_rd_q;
    data_cnt_d    = data_cnt_q;
    full_cnt_d    = full_cnt_q;
    owed_cnt_d    = owed_cnt_q;
    outstanding_d = outstanding_q;
    escape_d      = escape_q;
    awvalid_d     = awvalid_q;
    awaddr_d      = awaddr_q;
    awlen_d       = awlen_q;

    if (clk_en) begin
      if (req_push) req_wr_d = req_wr_q + RAW'(1);
      if (aw_load) req_rd_d = req_rd_q + RAW'(1);
      unique case ({req_push, aw_load})
        2'b10:   req_cnt_d = req_cnt_q + RCW'(1);
        2'b01:   req_cnt_d = req_cnt_q - RCW'(1);
        default: req_cnt_d = req_cnt_q;
      endcase

      if (data_push) data_wr_d = data_wr_q + DAW'(1);
      if (data_pop) data_rd_d = data_rd_q + DAW'(1);
      unique case ({data_push, data_pop})
        2'b10:   data_cnt_d = data_cnt_q + CW'(1);
        2'b01:   data_cnt_d = data_cnt_q - CW'(1);
        default: data_cnt_d = data_cnt_q;
      endcase

      unique case ({push_last, pop_last})
        2'b10:   full_cnt_d = full_cnt_q + CW'(1);
        2'b01:   full_cnt_d = full_cnt_q - CW'(1);
        default: full_cnt_d = full_cnt_q;
      endcase

      unique case ({aw_load, pop_last})
        2'b10:   owed_cnt_d = owed_cnt_q + CW'(1);
        2'b01:   owed_cnt_d = owed_cnt_q - CW'(1);
        default: owed_cnt_d = owed_cnt_q;
      endcase

      // Saturating decrement drops B responses that have no matching AW.
      if (aw_load && !b_hs) outstanding_d = outstanding_q + 8'd1;
      else if (!aw_load && b_hs && outstanding_q != 8'd0) outstanding_d = outstanding_q - 8'd1;

      if (data_cnt_q == DataFull && full_cnt_q == '0) escape_d = 1'b1;
      if (pop_last && owed_cnt_q == CW'(1)) escape_d = 1'b0;

      if (aw_load) begin
        awvalid_d = 1'b1;
        awaddr_d  = req_head[ADDR_WIDTH-1:0];
        awlen_d   = req_head[RW-1 -: LEN_WIDTH];
      end else if (in_BUS_AWREADY) begin
        awvalid_d = 1'b0;
      end
    end
  end

  // Ready flags are registered so both read 0 during the reset cycle.
  always_comb begin
    req_full_n_d  = (req_cnt_d != ReqFull);
    data_full_n_d = (data_cnt_d != DataFull);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_wr_q      <= '0;
      req_rd_q      <= '0;
      req_cnt_q     <= '0;
      req_full_n_q  <= 1'b0;
      data_wr_q     <= '0;
      data_rd_q     <= '0;
      data_cnt_q    <= '0;
      data_full_n_q <= 1'b0;
      full_cnt_q    <= '0;
      owed_cnt_q    <= '0;
      outstanding_q <= '0;
      escape_q      <= 1'b0;
      awvalid_q     <= 1'b0;
      awaddr_q      <= '0;
      awlen_q       <= '0;
    end else begin
      req_wr_q      <= req_wr_d;
      req_rd_q      <= req_rd_d;
      req_cnt_q     <= req_cnt_d;
      req_full_n_q  <= req_full_n_d;
      data_wr_q     <= data_wr_d;
      data_rd_q     <= data_rd_d;
      data_cnt_q    <= data_cnt_d;
      data_full_n_q <= data_full_n_d;
      full_cnt_q    <= full_cnt_d;
      owed_cnt_q    <= owed_cnt_d;
      outstanding_q <= outstanding_d;
      escape_q      <= escape_d;
      awvalid_q     <= awvalid_d;
      awaddr_q      <= awaddr_d;
      awlen_q       <= awlen_d;
    end
  end

endmodule

// File: tb/tb_kernel3_gmem_c_m_axi_wthrottle_mo.sv
// Directed bench for the write throttle; built with MAX_OUTSTANDING=2 to exercise the cap.
module tb_kernel3_gmem_c_m_axi_wthrottle_mo;

  logic        clk, reset_n, clk_en;
  logic [31:0] in_TOP_AWADDR;
  logic [7:0]  in_TOP_AWLEN;
  logic        in_TOP_AWVALID, out_TOP_AWREADY;
  logic [31:0] in_TOP_WDATA;
  logic [3:0]  in_TOP_WSTRB;
  logic        in_TOP_WLAST, in_TOP_WVALID, out_TOP_WREADY;
  logic [31:0] out_BUS_AWADDR;
  logic [7:0]  out_BUS_AWLEN;
  logic        out_BUS_AWVALID, in_BUS_AWREADY;
  logic [31:0] out_BUS_WDATA;
  logic [3:0]  out_BUS_WSTRB;
  logic        out_BUS_WLAST, out_BUS_WVALID, in_BUS_WREADY;
  logic        in_BUS_BVALID, in_BUS_BREADY;
  logic [7:0]  out_outstanding;
  logic        out_escape;

  int checks = 0;
  int passes = 0;

  kernel3_gmem_c_m_axi_wthrottle_mo #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8),
    .DATA_DEPTH(16), .MAXREQS(16), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .in_TOP_AWADDR(in_TOP_AWADDR), .in_TOP_AWLEN(in_TOP_AWLEN),
    .in_TOP_AWVALID(in_TOP_AWVALID), .out_TOP_AWREADY(out_TOP_AWREADY),
    .in_TOP_WDATA(in_TOP_WDATA), .in_TOP_WSTRB(in_TOP_WSTRB), .in_TOP_WLAST(in_TOP_WLAST),
    .in_TOP_WVALID(in_TOP_WVALID), .out_TOP_WREADY(out_TOP_WREADY),
    .out_BUS_AWADDR(out_BUS_AWADDR), .out_BUS_AWLEN(out_BUS_AWLEN),
    .out_BUS_AWVALID(out_BUS_AWVALID), .in_BUS_AWREADY(in_BUS_AWREADY),
    .out_BUS_WDATA(out_BUS_WDATA), .out_BUS_WSTRB(out_BUS_WSTRB),
    .out_BUS_WLAST(out_BUS_WLAST), .out_BUS_WVALID(out_BUS_WVALID),
    .in_BUS_WREADY(in_BUS_WREADY), .in_BUS_BVALID(in_BUS_BVALID),
    .in_BUS_BREADY(in_BUS_BREADY), .out_outstanding(out_outstanding), .out_escape(out_escape)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    clk_en = 1'b1;
    in_TOP_AWADDR = '0; in_TOP_AWLEN = '0; in_TOP_AWVALID = 1'b0;
    in_TOP_WDATA = '0; in_TOP_WSTRB = 4'hF; in_TOP_WLAST = 1'b0; in_TOP_WVALID = 1'b0;
    in_BUS_AWREADY = 1'b0; in_BUS_WREADY = 1'b0; in_BUS_BVALID = 1'b0; in_BUS_BREADY = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset;
    clear_inputs();
    reset_n = 1'b0;
    step();
    checks++; if (out_TOP_AWREADY !== 1'b0) $display("FAIL rst_awready got %b want 0", out_TOP_AWREADY); else passes++;
    checks++; if (out_TOP_WREADY !== 1'b0) $display("FAIL rst_wready got %b want 0", out_TOP_WREADY); else passes++;
    checks++; if (out_BUS_AWVALID !== 1'b0) $display("FAIL rst_awvalid got %b want 0", out_BUS_AWVALID); else passes++;
    checks++; if (out_BUS_WVALID !== 1'b0) $display("FAIL rst_wvalid got %b want 0", out_BUS_WVALID); else passes++;
    checks++; if (out_outstanding !== 8'd0) $display("FAIL rst_outstanding got %0d want 0", out_outstanding); else passes++;
    checks++; if (out_escape !== 1'b0) $display("FAIL rst_escape got %b want 0", out_escape); else passes++;
    reset_n = 1'b1;
    step();
    checks++; if (out_TOP_AWREADY !== 1'b1) $display("FAIL rst_awready_after got %b want 1", out_TOP_AWREADY); else passes++;
    checks++; if (out_TOP_WREADY !== 1'b1) $display("FAIL rst_wready_after got %b want 1", out_TOP_WREADY); else passes++;
    checks++; if (out_BUS_WDATA !== 32'd0) $display("FAIL rst_wdata got %h want 0", out_BUS_WDATA); else passes++;
  endtask

  task automatic test_single_burst;
    do_reset();
    in_TOP_AWADDR = 32'h1000; in_TOP_AWLEN = 8'd3; in_TOP_AWVALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_TOP_WVALID = 1'b1; in_TOP_WDATA = 32'hA0 + 32'(i);
      in_TOP_WSTRB = (i == 0) ? 4'h5 : 4'hF; in_TOP_WLAST = (i == 3);
      step();
      in_TOP_AWVALID = 1'b0;
    end
    in_TOP_WVALID = 1'b0; in_TOP_WLAST = 1'b0;
    checks++; if (out_BUS_AWVALID !== 1'b0) $display("FAIL single_aw_early got %b want 0", out_BUS_AWVALID); else passes++;
    checks++; if (out_BUS_WVALID !== 1'b0) $display("FAIL single_w_early got %b want 0", out_BUS_WVALID); else passes++;
    step();
    checks++; if (out_BUS_AWVALID !== 1'b1) $display("FAIL single_awvalid got %b want 1", out_BUS_AWVALID); else passes++;
    checks++; if (out_BUS_AWADDR !== 32'h1000) $display("FAIL single_awaddr got %h want 1000", out_BUS_AWADDR); else passes++;
    checks++; if (out_BUS_AWLEN !== 8'd3) $display("FAIL single_awlen got %0d want 3", out_BUS_AWLEN); else passes++;
    checks++; if (out_BUS_WVALID !== 1'b1) $display("FAIL single_wvalid got %b want 1", out_BUS_WVALID); else passes++;
    checks++; if (out_BUS_WDATA !== 32'hA0) $display("FAIL single_wdata0 got %h want a0", out_BUS_WDATA); else passes++;
    checks++; if (out_BUS_WSTRB !== 4'h5) $display("FAIL single_wstrb0 got %h want 5", out_BUS_WSTRB); else passes++;
    checks++; if (out_outstanding !== 8'd1) $display("FAIL single_out1 got %0d want 1", out_outstanding); else passes++;
    step();
    checks++; if (out_BUS_AWVALID !== 1'b1) $display("FAIL single_aw_hold got %b want 1", out_BUS_AWVALID); else passes++;
    checks++; if (out_BUS_AWADDR !== 32'h1000) $display("FAIL single_addr_hold got %h want 1000", out_BUS_AWADDR); else passes++;
    in_BUS_AWREADY = 1'b1; in_BUS_WREADY = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      checks++; if (out_BUS_WDATA !== 32'hA0 + 32'(i)) $display("FAIL single_wdata%0d got %h want %h", i, out_BUS_WDATA, 32'hA0 + 32'(i)); else passes++;
      checks++; if (out_BUS_WLAST !== (i == 3)) $display("FAIL single_wlast%0d got %b want %b", i, out_BUS_WLAST, (i == 3)); else passes++;
    end
    checks++; if (out_BUS_AWVALID !== 1'b0) $display("FAIL single_aw_done got %b want 0", out_BUS_AWVALID); else passes++;
    step();
    checks++; if (out_BUS_WVALID !== 1'b0) $display("FAIL single_w_done got %b want 0", out_BUS_WVALID); else passes++;
    checks++; if (dut.full_cnt_q !== 5'd0) $display("FAIL single_full_cnt got %0d want 0", dut.full_cnt_q); else passes++;
    checks++; if (out_outstanding !== 8'd1) $display("FAIL single_out_hold got %0d want 1", out_outstanding); else passes++;
    in_BUS_BVALID = 1'b1; in_BUS_BREADY = 1'b1;
    step();
    in_BUS_BVALID = 1'b0; in_BUS_BREADY = 1'b0;
    checks++; if (out_outstanding !== 8'd0) $display("FAIL single_out_b got %0d want 0", out_outstanding); else passes++;
  endtask

  task automatic test_data_before_aw;
    do_reset();
    in_BUS_AWREADY = 1'b1; in_BUS_WREADY = 1'b1;
    in_TOP_WVALID = 1'b1; in_TOP_WLAST = 1'b1; in_TOP_WDATA = 32'hD0;
    step();
    in_TOP_WDATA = 32'hD1;
    step();
    in_TOP_WVALID = 1'b0; in_TOP_WLAST = 1'b0;
    checks++; if (dut.full_cnt_q !== 5'd2) $display("FAIL dba_full2 got %0d want 2", dut.full_cnt_q); else passes++;
    checks++; if (out_BUS_WVALID !== 1'b0) $display("FAIL dba_w_noaw got %b want 0", out_BUS_WVALID); else passes++;
    in_TOP_AWVALID = 1'b1; in_TOP_AWADDR = 32'h2000; in_TOP_AWLEN = 8'd0;
    step();
    checks++; if (out_BUS_WVALID !== 1'b0) $display("FAIL dba_w_pre got %b want 0", out_BUS_WVALID); else passes++;
    in_TOP_AWADDR = 32'h2040;
    step();
    in_TOP_AWVALID = 1'b0;
    checks++; if (out_BUS_AWADDR !== 32'h2000 || out_BUS_AWVALID !== 1'b1) $display("FAIL dba_aw0 got %b/%h want 1/2000", out_BUS_AWVALID, out_BUS_AWADDR); else passes++;
    checks++; if (out_BUS_WVALID !== 1'b1 || out_BUS_WDATA !== 32'hD0) $display("FAIL dba_w0 got %b/%h want 1/d0", out_BUS_WVALID, out_BUS_WDATA); else passes++;
    step();
    checks++; if (out_BUS_AWADDR !== 32'h2040 || out_BUS_AWVALID !== 1'b1) $display("FAIL dba_aw1 got %b/%h want 1/2040", out_BUS_AWVALID, out_BUS_AWADDR); else passes++;
    checks++; if (out_BUS_WDATA !== 32'hD1 || out_BUS_WLAST !== 1'b1) $display("FAIL dba_w1 got %h/%b want d1/1", out_BUS_WDATA, out_BUS_WLAST); else passes++;
    checks++; if (out_outstanding !== 8'd2) $display("FAIL dba_out2 got %0d want 2", out_outstanding); else passes++;
    step();
    checks++; if (out_BUS_AWVALID !== 1'b0 || out_BUS_WVALID !== 1'b0) $display("FAIL dba_idle got %b/%b want 0/0", out_BUS_AWVALID, out_BUS_WVALID); else passes++;
    checks++; if (dut.full_cnt_q !== 5'd0) $display("FAIL dba_full0 got %0d want 0", dut.full_cnt_q); else passes++;
  endtask

  task automatic test_outstanding_cap;
    do_reset();
    in_BUS_AWREADY = 1'b1; in_BUS_WREADY = 1'b1;
    in_TOP_WVALID = 1'b1; in_TOP_WLAST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_TOP_WDATA = 32'hC0 + 32'(i);
      step();
    end
    in_TOP_WVALID = 1'b0; in_TOP_WLAST = 1'b0;
    in_TOP_AWVALID = 1'b1; in_TOP_AWLEN = 8'd0;
    for (int i = 0; i < 3; i++) begin
      in_TOP_AWADDR = 32'h3000 + 32'(i * 'h40);
      step();
    end
    in_TOP_AWVALID = 1'b0;
    checks++; if (out_BUS_AWADDR !== 32'h3040 || out_BUS_AWVALID !== 1'b1) $display("FAIL cap_aw1 got %b/%h want 1/3040", out_BUS_AWVALID, out_BUS_AWADDR); else passes++;
    checks++; if (out_outstanding !== 8'd2) $display("FAIL cap_out2 got %0d want 2", out_outstanding); else passes++;
    step();
    checks++; if (out_BUS_AWVALID !== 1'b0) $display("FAIL cap_blocked got %b want 0", out_BUS_AWVALID); else passes++;
    checks++; if (out_BUS_WVALID !== 1'b0) $display("FAIL cap_w_blocked got %b want 0", out_BUS_WVALID); else passes++;
    step();
    checks++; if (out_BUS_AWVALID !== 1'b0) $display("FAIL cap_still_blocked got %b want 0", out_BUS_AWVALID); else passes++;
    in_BUS_BVALID = 1'b1; in_BUS_BREADY = 1'b1;
    step();
    in_BUS_BVALID = 1'b0; in_BUS_BREADY = 1'b0;
    checks++; if (out_outstanding !== 8'd1 || out_BUS_AWVALID !== 1'b0) $display("FAIL cap_after_b got %0d/%b want 1/0", out_outstanding, out_BUS_AWVALID); else passes++;
    step();
    checks++; if (out_BUS_AWADDR !== 32'h3080 || out_BUS_AWVALID !== 1'b1) $display("FAIL cap_aw2 got %b/%h want 1/3080", out_BUS_AWVALID, out_BUS_AWADDR); else passes++;
    checks++; if (out_BUS_WVALID !== 1'b1 || out_BUS_WDATA !== 32'hC2) $display("FAIL cap_w2 got %b/%h want 1/c2", out_BUS_WVALID, out_BUS_WDATA); else passes++;
    step();
    checks++; if (out_BUS_AWVALID !== 1'b0 || out_BUS_WVALID !== 1'b0) $display("FAIL cap_idle got %b/%b want 0/0", out_BUS_AWVALID, out_BUS_WVALID); else passes++;
  endtask

  task automatic test_simultaneous;
    do_reset();
    in_BUS_AWREADY = 1'b1; in_BUS_WREADY = 1'b1;
    in_TOP_AWVALID = 1'b1; in_TOP_AWADDR = 32'h5000; in_TOP_AWLEN = 8'd0;
    in_TOP_WVALID = 1'b1; in_TOP_WLAST = 1'b1; in_TOP_WDATA = 32'hF0;
    step();
    in_TOP_AWVALID = 1'b0; in_TOP_WVALID = 1'b0;
    step();
    step();
    checks++; if (out_outstanding !== 8'd1) $display("FAIL sim_out_pre got %0d want 1", out_outstanding); else passes++;
    in_TOP_AWVALID = 1'b1; in_TOP_AWADDR = 32'h5040;
    in_TOP_WVALID = 1'b1; in_TOP_WDATA = 32'hF1;
    step();
    in_TOP_AWVALID = 1'b0; in_TOP_WVALID = 1'b0;
    in_BUS_BVALID = 1'b1; in_BUS_BREADY = 1'b1;
    step();
    in_BUS_BVALID = 1'b0; in_BUS_BREADY = 1'b0;
    checks++; if (out_outstanding !== 8'd1) $display("FAIL sim_out_incdec got %0d want 1", out_outstanding); else passes++;
    checks++; if (out_BUS_AWVALID !== 1'b1 || out_BUS_AWADDR !== 32'h5040) $display("FAIL sim_aw got %b/%h want 1/5040", out_BUS_AWVALID, out_BUS_AWADDR); else passes++;
    checks++; if (out_BUS_WVALID !== 1'b1 || out_BUS_WDATA !== 32'hF1) $display("FAIL sim_w got %b/%h want 1/f1", out_BUS_WVALID, out_BUS_WDATA); else passes++;
    in_TOP_WVALID = 1'b1; in_TOP_WDATA = 32'hF2;
    step();
    in_TOP_WVALID = 1'b0; in_TOP_WLAST = 1'b0;
    checks++; if (dut.full_cnt_q !== 5'd1) $display("FAIL sim_full_pushpop got %0d want 1", dut.full_cnt_q); else passes++;
    checks++; if (out_BUS_WVALID !== 1'b0) $display("FAIL sim_w_unowed got %b want 0", out_BUS_WVALID); else passes++;
  endtask

  task automatic test_escape;
    int pushed, rx, esc_at, data_err;
    logic pr, aw_seen;
    logic [7:0] aw_len;
    do_reset();
    in_BUS_AWREADY = 1'b1; in_BUS_WREADY = 1'b1;
    in_TOP_AWVALID = 1'b1; in_TOP_AWADDR = 32'h4000; in_TOP_AWLEN = 8'd31;
    pushed = 0; rx = 0; esc_at = -1; data_err = 0; aw_seen = 1'b0; aw_len = '0;
    for (int cyc = 0; cyc < 300 && rx < 32; cyc++) begin
      in_TOP_WVALID = (pushed < 32);
      in_TOP_WDATA = 32'hE000 + 32'(pushed);
      in_TOP_WLAST = (pushed == 31);
      pr = out_TOP_WREADY & in_TOP_WVALID;
      if (out_escape && esc_at < 0) esc_at = pushed;
      if (out_BUS_AWVALID) begin aw_seen = 1'b1; aw_len = out_BUS_AWLEN; end
      if (out_BUS_WVALID) begin
        if (out_BUS_WDATA !== 32'hE000 + 32'(rx) || out_BUS_WLAST !== (rx == 31)) data_err++;
        rx++;
      end
      step();
      in_TOP_AWVALID = 1'b0;
      if (pr) pushed++;
    end
    in_TOP_WVALID = 1'b0; in_TOP_WLAST = 1'b0;
    checks++; if (esc_at != 16) $display("FAIL esc_set_point got %0d want 16", esc_at); else passes++;
    checks++; if (aw_seen !== 1'b1 || aw_len !== 8'd31) $display("FAIL esc_aw got %b/%0d want 1/31", aw_seen, aw_len); else passes++;
    checks++; if (rx != 32) $display("FAIL esc_beats got %0d want 32", rx); else passes++;
    checks++; if (data_err != 0) $display("FAIL esc_data got %0d errors want 0", data_err); else passes++;
    checks++; if (out_escape !== 1'b0) $display("FAIL esc_clear got %b want 0", out_escape); else passes++;
    checks++; if (out_outstanding !== 8'd1) $display("FAIL esc_out got %0d want 1", out_outstanding); else passes++;
    checks++; if (dut.full_cnt_q !== 5'd0) $display("FAIL esc_full got %0d want 0", dut.full_cnt_q); else passes++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    in_TOP_AWVALID = 1'b1; in_TOP_AWADDR = 32'h6000; in_TOP_AWLEN = 8'd2;
    for (int i = 0; i < 3; i++) begin
      in_TOP_WVALID = 1'b1; in_TOP_WDATA = 32'hB0 + 32'(i); in_TOP_WLAST = (i == 2);
      step();
      in_TOP_AWVALID = 1'b0;
    end
    in_TOP_WVALID = 1'b0; in_TOP_WLAST = 1'b0;
    step();
    checks++; if (out_BUS_AWVALID !== 1'b1 || out_outstanding !== 8'd1) $display("FAIL mid_pre got %b/%0d want 1/1", out_BUS_AWVALID, out_outstanding); else passes++;
    clk_en = 1'b0;
    #1;
    checks++; if (out_TOP_AWREADY !== 1'b0 || out_TOP_WREADY !== 1'b0) $display("FAIL clken_ready got %b/%b want 0/0", out_TOP_AWREADY, out_TOP_WREADY); else passes++;
    checks++; if (out_BUS_WVALID !== 1'b0) $display("FAIL clken_wvalid got %b want 0", out_BUS_WVALID); else passes++;
    in_BUS_AWREADY = 1'b1;
    step();
    checks++; if (out_BUS_AWVALID !== 1'b1 || out_outstanding !== 8'd1) $display("FAIL clken_frozen got %b/%0d want 1/1", out_BUS_AWVALID, out_outstanding); else passes++;
    clk_en = 1'b1; in_BUS_AWREADY = 1'b0;
    reset_n = 1'b0;
    step();
    checks++; if (out_BUS_AWVALID !== 1'b0 || out_BUS_WVALID !== 1'b0) $display("FAIL mid_valids got %b/%b want 0/0", out_BUS_AWVALID, out_BUS_WVALID); else passes++;
    checks++; if (out_outstanding !== 8'd0 || dut.full_cnt_q !== 5'd0) $display("FAIL mid_counters got %0d/%0d want 0/0", out_outstanding, dut.full_cnt_q); else passes++;
    checks++; if (out_TOP_AWREADY !== 1'b0) $display("FAIL mid_awready got %b want 0", out_TOP_AWREADY); else passes++;
    reset_n = 1'b1;
    step();
    in_BUS_BVALID = 1'b1; in_BUS_BREADY = 1'b1;
    step();
    in_BUS_BVALID = 1'b0; in_BUS_BREADY = 1'b0;
    checks++; if (out_outstanding !== 8'd0) $display("FAIL mid_stray_b got %0d want 0", out_outstanding); else passes++;
    step();
    checks++; if (out_BUS_AWVALID !== 1'b0 || out_BUS_WVALID !== 1'b0) $display("FAIL mid_empty got %b/%b want 0/0", out_BUS_AWVALID, out_BUS_WVALID); else passes++;
  endtask

  initial begin
    reset_n = 1'b1;
    clear_inputs();
    test_reset();
    test_single_burst();
    test_data_before_aw();
    test_outstanding_cap();
    test_simultaneous();
    test_escape();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
